// File: rtl/vx_alu_commit_arb.sv
// Commit-response arbiter: merges NUM_INPUTS buffered sub-unit streams into one
// registered commit stream with selectable round-robin / fixed / aging policy.
module vx_alu_commit_arb #(
    parameter int  NUM_INPUTS = 3,
    parameter int  DATAW      = 128,
    parameter int  BUF_DEPTH  = 2,
    parameter int  ARB_MODE   = 0,
    parameter int  MAX_WAIT   = 7,
    localparam int SEL_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_INPUTS-1:0]       valid_in,
    input  logic [NUM_INPUTS*DATAW-1:0] data_in,
    output logic [NUM_INPUTS-1:0]       ready_in,
    output logic                        valid_out,
    output logic [DATAW-1:0]            data_out,
    output logic [SEL_W-1:0]            sel_out,
    input  logic                        ready_out,
    output logic [31:0]                 conflict_cnt
);

    localparam int         PTR_W    = $clog2(BUF_DEPTH);
    localparam int         CNT_W    = PTR_W + 1;
    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    logic [DATAW-1:0]      mem      [NUM_INPUTS][BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr   [NUM_INPUTS];
    logic [PTR_W-1:0]      rd_ptr   [NUM_INPUTS];
    logic [CNT_W-1:0]      count    [NUM_INPUTS];
    logic [7:0]            wait_cnt [NUM_INPUTS];

    logic [NUM_INPUTS-1:0] full, head_valid, push, pop, pri_mask;
    logic [SEL_W-1:0]      rr_ptr, grant_idx;
    logic [DATAW-1:0]      head_data;
    logic [3:0]            num_valid;
    logic                  adv, grant_any, found;

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            full[i]       = (count[i] == CNT_W'(BUF_DEPTH));
            head_valid[i] = (count[i] != '0);
        end
    end

    // No path from ready_out: a full FIFO refuses a push even when it pops.
    assign ready_in  = reset_n ? ~full : '0;
    assign push      = valid_in & ready_in;
    assign adv       = ~valid_out | ready_out;
    assign grant_any = |head_valid;

    // NOTE: every variable in a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        pri_mask  = '0;
        grant_idx = '0;
        found     = 1'b0;
        num_valid = '0;
        pop       = '0;
        head_data = '0;
        for (int j = 0; j < NUM_INPUTS; j++) begin
            case (ARB_MODE)
                0:       pri_mask[j] = head_valid[j] & (SEL_W'(j) >= rr_ptr);
                2:       pri_mask[j] = head_valid[j] & (wait_cnt[j] == WAIT_MAX);
                default: pri_mask[j] = 1'b0;
            endcase
        end
        // First pass picks the preferred set (rr window or aged heads), second falls back to lowest index.
        for (int j = 0; j < NUM_INPUTS; j++) begin
            if (!found && pri_mask[j]) begin
                grant_idx = SEL_W'(j);
                found     = 1'b1;
            end
        end
        for (int j = 0; j < NUM_INPUTS; j++) begin
            if (!found && head_valid[j]) begin
                grant_idx = SEL_W'(j);
                found     = 1'b1;
            end
        end
        for (int j = 0; j < NUM_INPUTS; j++) begin
            num_valid = num_valid + 4'(head_valid[j]);
            if (grant_idx == SEL_W'(j)) begin
                head_data = mem[j][rd_ptr[j]];
                pop[j]    = adv & grant_any;
            end
        end
    end

    // NOTE: payload storage carries no reset; occupancy counters alone decide what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= data_in[i*DATAW +: DATAW];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                wr_ptr[i]   <= '0;
                rd_ptr[i]   <= '0;
                count[i]    <= '0;
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CNT_W'(1);
                    2'b01:   count[i] <= count[i] - CNT_W'(1);
                    default: count[i] <= count[i];
                endcase
                if (!head_valid[i] || pop[i])
                    wait_cnt[i] <= '0;
                else if (adv && wait_cnt[i] != WAIT_MAX)
                    wait_cnt[i] <= wait_cnt[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_out    <= 1'b0;
            data_out     <= '0;
            sel_out      <= '0;
            rr_ptr       <= '0;
            conflict_cnt <= '0;
        end else if (adv) begin
            valid_out <= grant_any;
            if (grant_any) begin
                data_out <= head_data;
                sel_out  <= grant_idx;
                rr_ptr   <= (grant_idx == SEL_W'(NUM_INPUTS - 1)) ? '0 : grant_idx + SEL_W'(1);
                if (num_valid >= 4'd2) conflict_cnt <= conflict_cnt + 32'd1;
            end
        end
    end

endmodule
